// File: rtl/seq_gen_tx_if.sv
// seq_gen_tx_if -- handshake/data bundle for the serial pattern transmitter.
//   start     : request to begin a transmission (master -> slave)
//   pat       : PAT_W-bit pattern, sent MSB first (master -> slave)
//   reps      : number of back-to-back repetitions, 0..15 (master -> slave)
//   out       : serial data bit (slave -> master)
//   out_valid : out carries a pattern bit (slave -> master)
//   busy      : transmitter is sending (slave -> master)
//   done      : one-cycle completion pulse (slave -> master)
interface seq_gen_tx_if #(
  parameter int PAT_W = 4
);
  logic             start;
  logic [PAT_W-1:0] pat;
  logic [3:0]       reps;
  logic             out;
  logic             out_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, pat, reps,
    input  out, out_valid, busy, done
  );

  modport slave (
    input  start, pat, reps,
    output out, out_valid, busy, done
  );
endinterface

// File: rtl/seq_gen_tx.sv
// seq_gen_tx -- serializes a PAT_W-bit pattern MSB first, repeated 'reps'
// times back to back, then emits a one-cycle done pulse.
// Ports:
//   clk : clock, all state changes on its rising edge
//   rst : synchronous active-high reset
//   bus : seq_gen_tx_if slave modport (start/pat/reps in, out/out_valid/busy/done out)
// Every output is a register updated together with the state, so the value
// seen in a cycle always corresponds to the state held in that cycle.
module seq_gen_tx #(
  parameter int   PAT_W    = 4,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  seq_gen_tx_if.slave     bus
);

  localparam int BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [PAT_W-1:0] pat_reg;    // captured pattern, reloaded for each repetition
  logic [PAT_W-1:0] shift_reg;  // bits of the current repetition not yet on out
  logic [3:0]       rep_cnt;    // repetitions remaining, including the current one
  logic [BIT_W-1:0] bit_cnt;    // index of the bit currently on out
  logic             out_reg;
  logic             out_valid_reg;
  logic             busy_reg;
  logic             done_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      pat_reg       <= '0;
      shift_reg     <= '0;
      rep_cnt       <= '0;
      bit_cnt       <= '0;
      out_reg       <= IDLE_BIT;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          out_reg       <= IDLE_BIT;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
          done_reg      <= 1'b0;
          if (bus.start) begin
            if (bus.reps != 4'd0) begin
              // The MSB goes straight to out so it is visible the cycle
              // after start is sampled; the remainder waits in shift_reg.
              pat_reg       <= bus.pat;
              shift_reg     <= bus.pat << 1;
              rep_cnt       <= bus.reps;
              bit_cnt       <= '0;
              out_reg       <= bus.pat[PAT_W-1];
              out_valid_reg <= 1'b1;
              busy_reg      <= 1'b1;
              state_reg     <= SEND;
            end else begin
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end
          end
        end

        SEND: begin
          if (bit_cnt == LAST_BIT) begin
            if (rep_cnt > 4'd1) begin
              // Seamless reload: first bit of the next repetition follows
              // the last bit of this one with no gap.
              rep_cnt   <= rep_cnt - 4'd1;
              bit_cnt   <= '0;
              out_reg   <= pat_reg[PAT_W-1];
              shift_reg <= pat_reg << 1;
            end else begin
              rep_cnt       <= '0;
              out_reg       <= IDLE_BIT;
              out_valid_reg <= 1'b0;
              busy_reg      <= 1'b0;
              done_reg      <= 1'b1;
              state_reg     <= DONE;
            end
          end else begin
            bit_cnt   <= bit_cnt + BIT_W'(1);
            out_reg   <= shift_reg[PAT_W-1];
            shift_reg <= shift_reg << 1;
          end
        end

        DONE: begin
          out_reg       <= IDLE_BIT;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
          done_reg      <= 1'b0;
          state_reg     <= IDLE;
        end

        default: begin
          out_reg       <= IDLE_BIT;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
          done_reg      <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign bus.out       = out_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;

endmodule

// File: tb/tb_seq_gen_tx.sv
// tb_seq_gen_tx -- directed self-checking bench for seq_gen_tx.
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, i.e. they show the cycle that edge started.
module tb_seq_gen_tx;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  seq_gen_tx_if #(.PAT_W(4)) bus ();

  seq_gen_tx #(.PAT_W(4), .IDLE_BIT(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".out"},   64'(bus.out),       64'd0);
    chk({tag, ".valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, ".busy"},  64'(bus.busy),      64'd0);
    chk({tag, ".done"},  64'(bus.done),      64'd0);
  endtask

  // Check n consecutive valid bits (bits[n-1] first), then the done pulse,
  // then the following idle cycle. Enters on the cycle of the first bit.
  task automatic expect_bits(input string tag, input logic [63:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s.bit%0d", tag, i),   64'(bus.out),       64'(bits[n-1-i]));
      chk($sformatf("%s.valid%0d", tag, i), 64'(bus.out_valid), 64'd1);
      chk($sformatf("%s.busy%0d", tag, i),  64'(bus.busy),      64'd1);
      chk($sformatf("%s.done%0d", tag, i),  64'(bus.done),      64'd0);
      step();
    end
    chk({tag, ".done_pulse"}, 64'(bus.done),      64'd1);
    chk({tag, ".done_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, ".done_busy"},  64'(bus.busy),      64'd0);
    chk({tag, ".done_out"},   64'(bus.out),       64'd0);
    step();
    chk_idle({tag, ".after"});
    $display("frame %s: %0d bits checked", tag, n);
  endtask

  task automatic kick(input logic [3:0] p, input logic [3:0] r);
    bus.pat   = p;
    bus.reps  = r;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.pat   = 4'b1010;
    bus.reps  = 4'd1;

    // Reset held with start asserted: nothing happens
    step();
    step();
    chk_idle("reset");
    step();
    chk_idle("reset_hold");
    rst       = 1'b0;
    bus.start = 1'b0;
    step();
    chk_idle("post_reset");

    // Single frame 1010
    kick(4'b1010, 4'd1);
    expect_bits("r1_1010", 64'hA, 4);

    // Three repetitions, contiguous
    kick(4'b1010, 4'd3);
    expect_bits("r3_1010", 64'hAAA, 12);

    // Maximum repetitions with an asymmetric pattern
    kick(4'b1001, 4'd15);
    expect_bits("r15_1001", {4'h0, {15{4'b1001}}}, 60);

    // reps = 0: straight to done, no valid bits
    kick(4'b1010, 4'd0);
    chk("r0.done",  64'(bus.done),      64'd1);
    chk("r0.valid", 64'(bus.out_valid), 64'd0);
    chk("r0.busy",  64'(bus.busy),      64'd0);
    step();
    chk_idle("r0.idle");
    $display("frame r0: done-only checked");

    // start re-pulsed and inputs changed during 2nd bit: ignored
    kick(4'b1010, 4'd1);
    chk("ign.bit0", 64'(bus.out), 64'd1);
    step();
    chk("ign.bit1", 64'(bus.out), 64'd0);
    bus.start = 1'b1;
    bus.pat   = 4'b0110;
    bus.reps  = 4'd5;
    step();
    bus.start = 1'b0;
    expect_bits("ign.tail", 64'h2, 2);
    step();
    chk_idle("ign.no_restart");
    $display("frame ign: no restart checked");

    // Reset during 3rd bit aborts without done
    kick(4'b1010, 4'd2);
    step();
    step();
    chk("abort.bit2", 64'(bus.out), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle("abort.rst");
    step();
    chk_idle("abort.after1");
    step();
    chk_idle("abort.after2");
    kick(4'b1010, 4'd1);
    expect_bits("abort.fresh", 64'hA, 4);

    // start held high: frames repeat with two idle cycles between
    bus.pat   = 4'b1100;
    bus.reps  = 4'd1;
    bus.start = 1'b1;
    step();
    expect_bits("held.f1", 64'hC, 4);
    step();
    bus.start = 1'b0;
    expect_bits("held.f2", 64'hC, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
